// File: rtl/seg_counter_scan.sv
// Debounced up/down/clear BCD counter over 1..4 digits with modulo wrap,
// driving a time-multiplexed common-anode 7-segment display (active-low).
module seg_counter_scan #(
  parameter int DIGITS      = 4,
  parameter int MODULO      = 10000,
  parameter int SAMPLE_DIV  = 250000,
  parameter int DEB_SAMPLES = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        btn0,
  input  logic        btn1,
  input  logic        btn2,
  output logic [6:0]  seg,
  output logic [3:0]  key0,
  output logic [15:0] count_bcd
);

  localparam int SAMPLE_W = $clog2(SAMPLE_DIV);
  localparam int DEB_W    = $clog2(DEB_SAMPLES);
  localparam int SCAN_W   = $clog2(SCAN_DIV);

  function automatic logic [15:0] to_bcd(input int v);
    int t;
    logic [15:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [15:0] MAX_BCD = to_bcd(MODULO - 1);

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b1100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0001100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Sample tick divider: strobe is high during the last cycle of each period.
  logic [SAMPLE_W-1:0] sample_cnt;
  logic                tick;

  assign tick = (sample_cnt == SAMPLE_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + SAMPLE_W'(1);
    end
  end

  // Bit order in the per-button vectors: [0]=inc, [1]=dec, [2]=clear.
  logic [2:0]       sync1, sync2, deb, press;
  logic [DEB_W-1:0] run [3];

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) run[i] <= '0;
    end else begin
      sync1 <= {btn2, btn1, btn0};
      sync2 <= sync1;
      press <= '0;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          if (sync2[i] != deb[i]) begin
            if (run[i] == DEB_W'(DEB_SAMPLES - 1)) begin
              deb[i]   <= sync2[i];
              run[i]   <= '0;
              press[i] <= sync2[i];
            end else begin
              run[i] <= run[i] + DEB_W'(1);
            end
          end else begin
            run[i] <= '0;
          end
        end
      end
    end
  end

  // BCD successor/predecessor with per-nibble carry and borrow.
  logic [15:0] count, inc_val, dec_val;
  logic        carry, borrow;

  always_comb begin
    inc_val = count;
    dec_val = count;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[i*4 +: 4] == 4'd9) begin
          inc_val[i*4 +: 4] = 4'd0;
        end else begin
          inc_val[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[i*4 +: 4] == 4'd0) begin
          dec_val[i*4 +: 4] = 4'd9;
        end else begin
          dec_val[i*4 +: 4] = count[i*4 +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    if (count == MAX_BCD) inc_val = '0;
    if (count == '0)      dec_val = MAX_BCD;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (press[2]) begin
      count <= '0;
    end else if (press[0] ^ press[1]) begin
      count <= press[0] ? inc_val : dec_val;
    end
  end

  assign count_bcd = count;

  // Display scan: one digit per SCAN_DIV cycles, seg and key0 registered together.
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [3:0]        nib;
  logic              blank;

  always_comb begin
    nib   = count[{idx, 2'b00} +: 4];
    blank = (BLANK_LZ != 0) && (idx != 2'd0) && ((count >> {idx, 2'b00}) == 16'd0);
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      key0     <= 4'b1111;
      seg      <= 7'b1111111;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      key0 <= ~(4'b1000 >> idx);
      seg  <= blank ? 7'b1111111 : decode(nib);
    end
  end

endmodule

// File: tb/tb_seg_counter_scan.sv
// Directed bench for seg_counter_scan: reset, debounce, BCD wrap, priority,
// scan/blanking, and asynchronous reset; second instance covers MODULO=60.
module tb_seg_counter_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b0 = 1'b0, b1 = 1'b0, b2 = 1'b0;
  logic        e0 = 1'b0, e1 = 1'b0;
  logic [6:0]  seg, seg2;
  logic [3:0]  key0, key2;
  logic [15:0] count, count2;
  int          errors = 0;
  int          checks = 0;
  int          cyc;

  seg_counter_scan #(.DIGITS(4), .MODULO(10000), .SAMPLE_DIV(4), .DEB_SAMPLES(3),
                     .SCAN_DIV(8), .BLANK_LZ(1)) dut (
    .clk_50mhz(clk), .rst_n(rst_n), .btn0(b0), .btn1(b1), .btn2(b2),
    .seg(seg), .key0(key0), .count_bcd(count));

  seg_counter_scan #(.DIGITS(4), .MODULO(60), .SAMPLE_DIV(4), .DEB_SAMPLES(3),
                     .SCAN_DIV(8), .BLANK_LZ(1)) dut60 (
    .clk_50mhz(clk), .rst_n(rst_n), .btn0(e0), .btn1(e1), .btn2(1'b0),
    .seg(seg2), .key0(key2), .count_bcd(count2));

  always #5 clk = ~clk;

  // Edges since reset release; tick edges are multiples of 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask = {dut60 dec, dut60 inc, clear, dec, inc}
  task automatic press(input logic [4:0] m);
    @(negedge clk);
    {e1, e0, b2, b1, b0} = m;
    ticks(20);
    {e1, e0, b2, b1, b0} = '0;
    ticks(20);
  endtask

  task automatic wait_key(input string tag, input logic [3:0] k);
    int n;
    n = 0;
    while (key0 !== k && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {12'd0, key0}, {12'd0, k});
  endtask

  task automatic glitch_low();
    while (((cyc + 1) % 4) != 3) @(negedge clk);
    b0 = 1'b0;
    @(negedge clk);
    b0 = 1'b1;
  endtask

  initial begin
    ticks(3);
    check("reset_count", count, 16'h0000);
    check("reset_key", {12'd0, key0}, 16'h000f);
    check("reset_seg", {9'd0, seg}, 16'h007f);
    rst_n = 1'b1;

    ticks(4);
    check("idle_key_d0", {12'd0, key0}, 16'h0007);
    check("idle_seg_d0", {9'd0, seg}, {9'd0, 7'b0000001});
    ticks(8);
    check("idle_key_d1", {12'd0, key0}, 16'h000b);
    check("idle_seg_d1", {9'd0, seg}, 16'h007f);
    ticks(8);
    check("idle_key_d2", {12'd0, key0}, 16'h000d);
    check("idle_seg_d2", {9'd0, seg}, 16'h007f);
    ticks(8);
    check("idle_key_d3", {12'd0, key0}, 16'h000e);
    check("idle_seg_d3", {9'd0, seg}, 16'h007f);
    ticks(8);
    check("idle_key_wrap", {12'd0, key0}, 16'h0007);
    check("idle_count", count, 16'h0000);

    b0 = 1'b1;
    ticks(4);
    b0 = 1'b0;
    ticks(30);
    check("short_pulse", count, 16'h0000);

    b0 = 1'b1;
    ticks(5);
    glitch_low();
    ticks(3);
    glitch_low();
    ticks(8);
    b0 = 1'b0;
    ticks(30);
    check("glitch_press", count, 16'h0001);

    repeat (8) press(5'b00001);
    check("count_9", count, 16'h0009);
    wait_key("key_d1_at9", 4'b1011);
    check("seg_d1_blank", {9'd0, seg}, 16'h007f);
    press(5'b00001);
    check("carry_10", count, 16'h0010);
    wait_key("key_d1_at10", 4'b1011);
    check("seg_d1_one", {9'd0, seg}, {9'd0, 7'b1001111});
    wait_key("key_d0_at10", 4'b0111);
    check("seg_d0_zero", {9'd0, seg}, {9'd0, 7'b0000001});

    press(5'b00011);
    check("inc_dec_same", count, 16'h0010);
    press(5'b00101);
    check("clear_over_inc", count, 16'h0000);
    press(5'b00010);
    check("dec_wrap", count, 16'h9999);
    wait_key("key_d3_at9999", 4'b1110);
    check("seg_d3_nine", {9'd0, seg}, {9'd0, 7'b0001100});

    press(5'b10000);
    check("m60_dec_wrap", count2, 16'h0059);
    press(5'b01000);
    check("m60_inc_wrap", count2, 16'h0000);
    check("m60_main_idle", count, 16'h9999);

    press(5'b00100);
    check("clear", count, 16'h0000);
    repeat (123) press(5'b00001);
    check("count_123", count, 16'h0123);
    wait_key("key_d2_at123", 4'b1101);
    check("seg_d2_one", {9'd0, seg}, {9'd0, 7'b1001111});
    wait_key("key_d3_at123", 4'b1110);
    check("seg_d3_blank", {9'd0, seg}, 16'h007f);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_key", {12'd0, key0}, 16'h000f);
    check("async_seg", {9'd0, seg}, 16'h007f);
    check("async_count", count, 16'h0000);
    ticks(3);
    rst_n = 1'b1;
    ticks(3);
    check("post_reset_count", count, 16'h0000);
    check("post_reset_key", {12'd0, key0}, 16'h0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
